alu_design_core: RTL and testbench

//  - 8-bit registered ALU: two operands, 3-bit opcode select, 16-bit result plus carry/borrow flag.
//  - Result width covers the full 8x8 product.
//  - Datapath leaf block; one clock domain; result registered, valid 1 cycle after inputs sampled.

---
 rtl/alu_design_core.sv | 94 +++++++++
 tb/tb_alu_design_core.sv | 136 +++++++++++++
 2 files changed

// File: rtl/alu_design_core.sv
// 8-bit registered ALU: ADD/SUB/MUL/AND/OR/XOR/NOT/SHL, 16-bit result plus carry flag, one cycle latency.
// Optional registered zero flag output enabled by defining ALU_ZERO_FLAG_EN.
module alu_design_core (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [2:0]  op_code,
  output logic [15:0] alu_out,
`ifdef ALU_ZERO_FLAG_EN
  output logic        zero,
`endif
  output logic        c_out
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_NOT = 3'b110;
  localparam logic [2:0] OP_SHL = 3'b111;

  logic [8:0]  w_sum;
  logic [8:0]  w_diff;
  logic [15:0] w_prod;
  logic [15:0] w_nextOut;
  logic        w_nextCarry;
  logic [15:0] r_aluOut;
  logic        r_cOut;

  assign w_sum  = {1'b0, A} + {1'b0, B};
  assign w_diff = {1'b0, A} - {1'b0, B};
  assign w_prod = {8'h00, A} * {8'h00, B};

  // Carry from ADD lives only in c_out; the result keeps the wrapped low byte.
  always_comb begin
    w_nextOut   = 16'h0000;
    w_nextCarry = 1'b0;
    case (op_code)
      OP_ADD: begin
        w_nextOut   = {8'h00, w_sum[7:0]};
        w_nextCarry = w_sum[8];
      end
      OP_SUB: begin
        w_nextOut   = {8'h00, w_diff[7:0]};
        w_nextCarry = (A < B);
      end
      OP_MUL: w_nextOut = w_prod;
      OP_AND: w_nextOut = {8'h00, A & B};
      OP_OR:  w_nextOut = {8'h00, A | B};
      OP_XOR: w_nextOut = {8'h00, A ^ B};
      OP_NOT: w_nextOut = {8'h00, ~A};
      OP_SHL: begin
        w_nextOut   = {7'h00, A, 1'b0};
        w_nextCarry = A[7];
      end
      default: begin
        w_nextOut   = 16'h0000;
        w_nextCarry = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_aluOut <= 16'h0000;
      r_cOut   <= 1'b0;
    end else begin
      r_aluOut <= w_nextOut;
      r_cOut   <= w_nextCarry;
    end
  end

  assign alu_out = r_aluOut;
  assign c_out   = r_cOut;

`ifdef ALU_ZERO_FLAG_EN
  logic r_zero;

  // Zero reflects the value being registered this edge, so it tracks alu_out exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_zero <= 1'b1;
    end else begin
      r_zero <= (w_nextOut == 16'h0000);
    end
  end

  assign zero = r_zero;
`endif

endmodule

// File: tb/tb_alu_design_core.sv
// Scoreboard bench for alu_design_core: stimulus pushes hand-computed expectations,
// a monitor pops and compares one entry per clock after the registering edge.
module tb_alu_design_core;

  logic        clk;
  logic        rst;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [2:0]  op_code;
  logic [15:0] alu_out;
  logic        c_out;
`ifdef ALU_ZERO_FLAG_EN
  logic        zero;
`endif

  typedef struct {
    logic [15:0] expOut;
    logic        expC;
    string       name;
  } expect_t;

  expect_t scoreQ[$];
  int      errors = 0;
  int      checks = 0;

  alu_design_core dut (
    .clk     (clk),
    .rst     (rst),
    .A       (A),
    .B       (B),
    .op_code (op_code),
    .alu_out (alu_out),
`ifdef ALU_ZERO_FLAG_EN
    .zero    (zero),
`endif
    .c_out   (c_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs and record what the following edge must produce.
  task automatic applyStimulus(input logic iRst, input logic [7:0] iA, input logic [7:0] iB,
                               input logic [2:0] iOp, input logic [15:0] expOut,
                               input logic expC, input string name);
    expect_t e;
    rst     = iRst;
    A       = iA;
    B       = iB;
    op_code = iOp;
    e.expOut = expOut;
    e.expC   = expC;
    e.name   = name;
    scoreQ.push_back(e);
    @(negedge clk);
  endtask

  task automatic checkOutput(input expect_t e);
    checks++;
    if (alu_out !== e.expOut) begin
      errors++;
      $display("[TB] FAIL %s alu_out: got %h expected %h", e.name, alu_out, e.expOut);
    end
    checks++;
    if (c_out !== e.expC) begin
      errors++;
      $display("[TB] FAIL %s c_out: got %b expected %b", e.name, c_out, e.expC);
    end
`ifdef ALU_ZERO_FLAG_EN
    checks++;
    if (zero !== (e.expOut == 16'h0000)) begin
      errors++;
      $display("[TB] FAIL %s zero: got %b expected %b", e.name, zero, (e.expOut == 16'h0000));
    end
`endif
  endtask

  // Monitor: every edge registers a result, so compare one queued entry per edge.
  initial begin
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      if (scoreQ.size() > 0) begin
        e = scoreQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    rst = 1'b1; A = 8'hFF; B = 8'h55; op_code = 3'b010;

    applyStimulus(1'b1, 8'hFF, 8'h55, 3'b010, 16'h0000, 1'b0, "reset0");
    applyStimulus(1'b1, 8'hFF, 8'h55, 3'b010, 16'h0000, 1'b0, "reset1");

    applyStimulus(1'b0, 8'hFF, 8'h55, 3'b000, 16'h0054, 1'b1, "add_ff_55");
    applyStimulus(1'b0, 8'hFF, 8'h55, 3'b001, 16'h00AA, 1'b0, "sub_ff_55");
    applyStimulus(1'b0, 8'hFF, 8'h55, 3'b010, 16'h54AB, 1'b0, "mul_ff_55");
    applyStimulus(1'b0, 8'hFF, 8'h55, 3'b011, 16'h0055, 1'b0, "and_ff_55");
    applyStimulus(1'b0, 8'hFF, 8'h55, 3'b100, 16'h00FF, 1'b0, "or_ff_55");
    applyStimulus(1'b0, 8'hFF, 8'h55, 3'b101, 16'h00AA, 1'b0, "xor_ff_55");
    applyStimulus(1'b0, 8'hFF, 8'h55, 3'b110, 16'h0000, 1'b0, "not_ff");
    applyStimulus(1'b0, 8'hFF, 8'h55, 3'b111, 16'h01FE, 1'b1, "shl_ff");

    applyStimulus(1'b0, 8'h00, 8'h01, 3'b001, 16'h00FF, 1'b1, "sub_borrow");
    applyStimulus(1'b0, 8'hFF, 8'hFF, 3'b010, 16'hFE01, 1'b0, "mul_ff_ff");
    applyStimulus(1'b0, 8'h00, 8'hFF, 3'b010, 16'h0000, 1'b0, "mul_00_ff");
    applyStimulus(1'b0, 8'h80, 8'h80, 3'b000, 16'h0000, 1'b1, "add_wrap");
    applyStimulus(1'b0, 8'h01, 8'h00, 3'b111, 16'h0002, 1'b0, "shl_01");
    applyStimulus(1'b0, 8'h3C, 8'h00, 3'b110, 16'h00C3, 1'b0, "not_3c");
    applyStimulus(1'b0, 8'h55, 8'h55, 3'b001, 16'h0000, 1'b0, "sub_equal");

    applyStimulus(1'b0, 8'h0F, 8'hF0, 3'b000, 16'h00FF, 1'b0, "lat_add");
    applyStimulus(1'b0, 8'h0F, 8'hF0, 3'b011, 16'h0000, 1'b0, "lat_and");

    applyStimulus(1'b0, 8'h01, 8'h02, 3'b000, 16'h0003, 1'b0, "stream_add0");
    applyStimulus(1'b1, 8'h05, 8'h06, 3'b000, 16'h0000, 1'b0, "stream_reset");
    applyStimulus(1'b0, 8'h03, 8'h04, 3'b000, 16'h0007, 1'b0, "stream_resume");
    applyStimulus(1'b0, 8'hF0, 8'h20, 3'b000, 16'h0010, 1'b1, "stream_carry");

    // Bounded drain of any outstanding expectations before summarising.
    for (int i = 0; i < 10 && scoreQ.size() > 0; i++) @(negedge clk);
    if (scoreQ.size() > 0) begin
      errors++;
      checks++;
      $display("[TB] FAIL drain: %0d entries left, required 0", scoreQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
